// File: rtl/mem_access_sequencer_if.sv
// Request/ack and memory-control signals between requesters, sequencer and memory subsystem.
// slave: the sequencer side; master: the requester/memory side.
interface mem_access_sequencer_if #(
    parameter int unsigned ADDR_W = 9
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic              fetch_ack;
    logic              data_ack;
    logic              busy;
    logic              addr_drive;
    logic [31:0]       addr_out;
    logic              MARin;
    logic              MDRin;
    logic              read;
    logic              write;

    modport slave (
        input  fetch_req, fetch_addr, data_req, data_we, data_addr,
        output fetch_ack, data_ack, busy, addr_drive, addr_out, MARin, MDRin, read, write
    );

    modport master (
        output fetch_req, fetch_addr, data_req, data_we, data_addr,
        input  fetch_ack, data_ack, busy, addr_drive, addr_out, MARin, MDRin, read, write
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// Arbitrates fetch/data requests and sequences MAR load, RAM access, MDR capture and ack.
// Define MEM_RR_ARB_EN for round-robin ties; otherwise data always beats fetch.
module mem_access_sequencer #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned RAM_LAT = 1
) (
    input logic                   clock,
    input logic                   clear,
    mem_access_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAccess,
        StCapture,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              gnt_data_q, gnt_data_d;
    logic              gnt_we_q, gnt_we_d;
    logic [ADDR_W-1:0] gnt_addr_q, gnt_addr_d;
    logic              pick_data;

`ifdef MEM_RR_ARB_EN
    // Set when data should win the next tie; cleared at reset so fetch goes first.
    logic prio_data_q, prio_data_d;

    always_ff @(posedge clock) begin
        if (!clear) begin
            prio_data_q <= 1'b0;
        end else begin
            prio_data_q <= prio_data_d;
        end
    end

    always_comb begin
        prio_data_d = prio_data_q;
        if (state_q == StDone) begin
            prio_data_d = ~gnt_data_q;
        end
    end

    assign pick_data = bus.data_req & (~bus.fetch_req | prio_data_q);
`else
    assign pick_data = bus.data_req;
`endif

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            gnt_data_q <= 1'b0;
            gnt_we_q   <= 1'b0;
            gnt_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_data_q <= gnt_data_d;
            gnt_we_q   <= gnt_we_d;
            gnt_addr_q <= gnt_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_data_d = gnt_data_q;
        gnt_we_d   = gnt_we_q;
        gnt_addr_d = gnt_addr_q;
        unique case (state_q)
            StIdle: begin
                if (bus.fetch_req || bus.data_req) begin
                    gnt_data_d = pick_data;
                    gnt_we_d   = pick_data & bus.data_we;
                    gnt_addr_d = pick_data ? bus.data_addr : bus.fetch_addr;
                    state_d    = StAddr;
                end
            end
            StAddr: begin
                cnt_d   = 4'(RAM_LAT - 1);
                state_d = StAccess;
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    state_d = gnt_we_q ? StDone : StCapture;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StCapture: state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs are a pure decode of the registered state and grant.
    always_comb begin
        bus.busy       = (state_q != StIdle);
        bus.addr_drive = (state_q == StAddr);
        bus.MARin      = (state_q == StAddr);
        bus.addr_out   = (state_q == StAddr) ? 32'(gnt_addr_q) : 32'd0;
        bus.read       = ((state_q == StAccess) && !gnt_we_q) || (state_q == StCapture);
        bus.write      = (state_q == StAccess) && gnt_we_q;
        bus.MDRin      = (state_q == StCapture);
        bus.fetch_ack  = (state_q == StDone) && !gnt_data_q;
        bus.data_ack   = (state_q == StDone) && gnt_data_q;
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench: sequencer with a small MAR/MDR/RAM model, plus a RAM_LAT=4 instance.
module tb_mem_access_sequencer;
    localparam int unsigned ADDR_W = 9;

    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    mem_access_sequencer_if #(.ADDR_W(ADDR_W)) b1 ();
    mem_access_sequencer_if #(.ADDR_W(ADDR_W)) b4 ();

    mem_access_sequencer #(.ADDR_W(ADDR_W), .RAM_LAT(1)) dut1 (
        .clock(clock),
        .clear(clear),
        .bus  (b1)
    );

    mem_access_sequencer #(.ADDR_W(ADDR_W), .RAM_LAT(4)) dut4 (
        .clock(clock),
        .clear(clear),
        .bus  (b4)
    );

    // Memory subsystem model for dut1, with a side port for preloading RAM/MDR.
    logic [31:0] ram [512];
    logic [8:0]  mar;
    logic [31:0] mdr;
    logic        cpu_mdr_wr, cpu_ram_wr;
    logic [8:0]  cpu_addr;
    logic [31:0] cpu_val;

    always @(posedge clock) begin
        if (b1.MARin) mar <= b1.addr_out[8:0];
        if (b1.MDRin && b1.read) mdr <= ram[mar];
        else if (cpu_mdr_wr) mdr <= cpu_val;
        if (b1.write) ram[mar] <= mdr;
        else if (cpu_ram_wr) ram[cpu_addr] <= cpu_val;
    end

    // {fetch_ack, data_ack, busy, addr_drive, MARin, MDRin, read, write}
    logic [7:0] ctrl1, ctrl4;
    assign ctrl1 = {b1.fetch_ack, b1.data_ack, b1.busy, b1.addr_drive,
                    b1.MARin, b1.MDRin, b1.read, b1.write};
    assign ctrl4 = {b4.fetch_ack, b4.data_ack, b4.busy, b4.addr_drive,
                    b4.MARin, b4.MDRin, b4.read, b4.write};

    localparam logic [7:0] CIdle = 8'h00, CAddr = 8'h38, CRd = 8'h22, CCap = 8'h26,
                           CWr = 8'h21, CFAck = 8'hA0, CDAck = 8'h60;

    int tests = 0;
    int failed = 0;
    int n_acks;
    logic [2:0] ack_who;
    logic [2:0] exp_who;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic exp1(input string tag, input logic [7:0] exp);
        step();
        check(tag, {24'd0, ctrl1}, {24'd0, exp});
    endtask

    task automatic exp4(input string tag, input logic [7:0] exp);
        step();
        check(tag, {24'd0, ctrl4}, {24'd0, exp});
    endtask

    initial begin
        clear = 1'b0;
        b1.fetch_req = 0; b1.fetch_addr = '0; b1.data_req = 0; b1.data_we = 0; b1.data_addr = '0;
        b4.fetch_req = 0; b4.fetch_addr = '0; b4.data_req = 0; b4.data_we = 0; b4.data_addr = '0;
        cpu_mdr_wr = 0; cpu_ram_wr = 0; cpu_addr = '0; cpu_val = '0;
        step();
        step();
        check("reset_ctrl1", {24'd0, ctrl1}, 32'd0);
        check("reset_addr1", b1.addr_out, 32'd0);
        check("reset_ctrl4", {24'd0, ctrl4}, 32'd0);
        clear = 1'b1;

        cpu_ram_wr = 1; cpu_addr = 9'h010; cpu_val = 32'hDEADBEEF;
        step();
        cpu_ram_wr = 0;

        // Fetch from 0x010
        b1.fetch_req = 1; b1.fetch_addr = 9'h010;
        exp1("fetch_addr_phase", CAddr);
        check("fetch_addr_out", b1.addr_out, 32'h0000_0010);
        exp1("fetch_access", CRd);
        exp1("fetch_capture", CCap);
        exp1("fetch_ack", CFAck);
        b1.fetch_req = 0;
        exp1("fetch_idle", CIdle);
        check("fetch_mdr", mdr, 32'hDEADBEEF);

        // Store 0x12345678 to 0x1FF
        cpu_mdr_wr = 1; cpu_val = 32'h12345678;
        step();
        cpu_mdr_wr = 0;
        b1.data_req = 1; b1.data_we = 1; b1.data_addr = 9'h1FF;
        exp1("store_addr_phase", CAddr);
        check("store_addr_out", b1.addr_out, 32'h0000_01FF);
        exp1("store_write", CWr);
        exp1("store_ack", CDAck);
        b1.data_req = 0; b1.data_we = 0;
        exp1("store_idle", CIdle);

        // Load back 0x1FF after clearing MDR
        cpu_mdr_wr = 1; cpu_val = 32'd0;
        step();
        cpu_mdr_wr = 0;
        b1.data_req = 1; b1.data_addr = 9'h1FF;
        exp1("load_addr_phase", CAddr);
        exp1("load_access", CRd);
        exp1("load_capture", CCap);
        exp1("load_ack", CDAck);
        b1.data_req = 0;
        exp1("load_idle", CIdle);
        check("load_mdr", mdr, 32'h12345678);

        // Address change in ADDR and req drop in ACCESS are ignored
        b1.fetch_req = 1; b1.fetch_addr = 9'h010;
        exp1("drop_addr_phase", CAddr);
        b1.fetch_addr = 9'h1FF;
        #1;
        check("drop_addr_out_held", b1.addr_out, 32'h0000_0010);
        exp1("drop_access", CRd);
        b1.fetch_req = 0;
        exp1("drop_capture", CCap);
        exp1("drop_ack", CFAck);
        exp1("drop_idle", CIdle);
        check("drop_mdr", mdr, 32'hDEADBEEF);

        // Reset during ACCESS aborts; held request is re-served
        b1.data_req = 1; b1.data_addr = 9'h010;
        exp1("rst_addr_phase", CAddr);
        exp1("rst_access", CRd);
        clear = 1'b0;
        exp1("rst_abort", CIdle);
        clear = 1'b1;
        exp1("rst_readdr", CAddr);
        exp1("rst_reaccess", CRd);
        exp1("rst_recapture", CCap);
        exp1("rst_reack", CDAck);
        b1.data_req = 0;
        exp1("rst_idle", CIdle);

        // Both requesters held: observe the order of three acks
`ifdef MEM_RR_ARB_EN
        exp_who = 3'b010;
`else
        exp_who = 3'b111;
`endif
        n_acks = 0;
        ack_who = '0;
        b1.fetch_req = 1; b1.fetch_addr = 9'h010;
        b1.data_req = 1; b1.data_we = 0; b1.data_addr = 9'h1FF;
        for (int c = 0; c < 40 && n_acks < 3; c++) begin
            step();
            if (b1.fetch_ack || b1.data_ack) begin
                ack_who[n_acks] = b1.data_ack;
                n_acks++;
            end
        end
        b1.fetch_req = 0; b1.data_req = 0;
        check("tie_ack_count", n_acks, 3);
        check("tie_ack0", {31'd0, ack_who[0]}, {31'd0, exp_who[0]});
        check("tie_ack1", {31'd0, ack_who[1]}, {31'd0, exp_who[1]});
        check("tie_ack2", {31'd0, ack_who[2]}, {31'd0, exp_who[2]});
        exp1("tie_idle", CIdle);

        // RAM_LAT=4 load: read held 5 cycles, ack at k+7
        b4.data_req = 1; b4.data_addr = 9'h005;
        exp4("lat4_addr_phase", CAddr);
        check("lat4_addr_out", b4.addr_out, 32'h0000_0005);
        for (int i = 0; i < 4; i++) exp4("lat4_access", CRd);
        exp4("lat4_capture", CCap);
        exp4("lat4_ack", CDAck);
        b4.data_req = 0;
        exp4("lat4_idle", CIdle);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
